// File: rtl/buffer_port_arbiter.sv
// -----------------------------------------------------------------------------
// buffer_port_arbiter
//
// Shares one single-port on-chip buffer between three requesters
// (0 = host loader, 1 = systolic array fetch, 2 = sort/crucial-token logic).
// Each requester asks for a burst of consecutive addresses. Bursts are
// granted round-robin. Once a burst is granted, this block drives the
// buffer pins for the whole burst and reports the owner on sel so the data
// mux can be steered by requester id.
//
// Ports:
//   CLK                 rising-edge clock
//   RESET               asynchronous, active-low reset
//   EN                  global enable; low pauses arbitration and bursts
//   req[2:0]            request level per requester
//   we[2:0]             direction per requester (1 write, 0 read)
//   base0/1/2 [AW-1:0]  burst start address per requester
//   len0/1/2  [LW-1:0]  burst length minus one per requester
//   gnt[2:0]            one-hot pulse on the first beat of a burst
//   done[2:0]           one-hot pulse on the last beat of a burst
//   sel[1:0]            owner of the current beat; holds when idle
//   busy                high for the whole burst, paused cycles included
//   mem_wen/ren/cen     buffer pins, {wen,ren,cen}:
//                       WRITE 011, READ 110, NOP 101
//   mem_addr[AW-1:0]    buffer address
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module buffer_port_arbiter #(
    parameter int AW = 13,
    parameter int LW = 7
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] base0,
    input  logic [AW-1:0] base1,
    input  logic [AW-1:0] base2,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic [LW-1:0] len2,
    output logic [2:0]    gnt,
    output logic [2:0]    done,
    output logic [1:0]    sel,
    output logic          busy,
    output logic          mem_wen,
    output logic          mem_ren,
    output logic          mem_cen,
    output logic [AW-1:0] mem_addr
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [2:0] PINS_WRITE = 3'b011;
    localparam logic [2:0] PINS_READ  = 3'b110;
    localparam logic [2:0] PINS_NOP   = 3'b101;

    // Buffer pin pattern for an active beat in the given direction.
    function automatic logic [2:0] pins_for(input logic wr);
        logic [2:0] p;
        if (wr) begin
            p = PINS_WRITE;
        end else begin
            p = PINS_READ;
        end
        return p;
    endfunction

    // One-hot vector for a requester id.
    function automatic logic [2:0] onehot3(input logic [1:0] id);
        logic [2:0] v;
        case (id)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Round-robin pick: first set request scanning last+1, last+2, last+3 mod 3.
    // Only meaningful when r is non-zero.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] w;
        case (last)
            2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (r[c0]) begin
            w = c0;
        end else if (r[c1]) begin
            w = c1;
        end else begin
            w = c2;
        end
        return w;
    endfunction

    // State and datapath flops
    logic [0:0]    state_q,  state_d;
    logic [LW-1:0] cnt_q,    cnt_d;
    logic [LW-1:0] len_q,    len_d;
    logic          we_q,     we_d;
    logic [1:0]    last_q,   last_d;
    logic          beat_q,   beat_d;    // a beat is on the pins this cycle
    logic [2:0]    pins_q,   pins_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [2:0]    gnt_q,    gnt_d;
    logic [2:0]    done_q,   done_d;
    logic [1:0]    sel_q,    sel_d;
    logic          busy_q,   busy_d;

    // Winner of the current arbitration and its request fields
    logic [1:0]    win_s;
    logic          win_we_s;
    logic [AW-1:0] win_base_s;
    logic [LW-1:0] win_len_s;
    logic [LW-1:0] cnt_inc_s;

    assign win_s     = rr_pick(req, last_q);
    assign cnt_inc_s = cnt_q + {{(LW-1){1'b0}}, 1'b1};

    // Select the winning requester's direction, base and length.
    always_comb begin
        win_we_s   = we[0];
        win_base_s = base0;
        win_len_s  = len0;
        case (win_s)
            2'd0: begin win_we_s = we[0]; win_base_s = base0; win_len_s = len0; end
            2'd1: begin win_we_s = we[1]; win_base_s = base1; win_len_s = len1; end
            2'd2: begin win_we_s = we[2]; win_base_s = base2; win_len_s = len2; end
            default: begin win_we_s = we[0]; win_base_s = base0; win_len_s = len0; end
        endcase
    end

    // Next-state logic for the arbitration / burst FSM and all output flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        we_d    = we_q;
        last_d  = last_q;
        beat_d  = 1'b0;
        pins_d  = PINS_NOP;
        addr_d  = addr_q;
        gnt_d   = 3'b000;
        done_d  = 3'b000;
        sel_d   = sel_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (EN && (req != 3'b000)) begin
                    // Beat 0 goes out on the cycle after arbitration.
                    state_d = ST_BURST;
                    sel_d   = win_s;
                    we_d    = win_we_s;
                    addr_d  = win_base_s;
                    len_d   = win_len_s;
                    cnt_d   = {LW{1'b0}};
                    busy_d  = 1'b1;
                    beat_d  = 1'b1;
                    pins_d  = pins_for(win_we_s);
                    gnt_d   = onehot3(win_s);
                    if (win_len_s == {LW{1'b0}}) begin
                        done_d = onehot3(win_s);
                    end else begin
                        done_d = 3'b000;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_BURST: begin
                if (beat_q) begin
                    if (cnt_q == len_q) begin
                        // Last beat just issued: one NOP turnaround cycle follows.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        last_d  = sel_q;
                    end else begin
                        // Advance to the next beat; it issues now or stays pending.
                        cnt_d  = cnt_inc_s;
                        addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
                        if (EN) begin
                            beat_d = 1'b1;
                            pins_d = pins_for(we_q);
                            if (cnt_inc_s == len_q) begin
                                done_d = onehot3(sel_q);
                            end else begin
                                done_d = 3'b000;
                            end
                        end else begin
                            beat_d = 1'b0;
                        end
                    end
                end else begin
                    // Paused: the pending beat at cnt_q/addr_q issues once EN returns.
                    if (EN) begin
                        beat_d = 1'b1;
                        pins_d = pins_for(we_q);
                        if (cnt_q == {LW{1'b0}}) begin
                            gnt_d = onehot3(sel_q);
                        end else begin
                            gnt_d = 3'b000;
                        end
                        if (cnt_q == len_q) begin
                            done_d = onehot3(sel_q);
                        end else begin
                            done_d = 3'b000;
                        end
                    end else begin
                        beat_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= {LW{1'b0}};
            len_q   <= {LW{1'b0}};
            we_q    <= 1'b0;
            last_q  <= 2'd2;
            beat_q  <= 1'b0;
            pins_q  <= PINS_NOP;
            addr_q  <= {AW{1'b0}};
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            we_q    <= we_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            pins_q  <= pins_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign {mem_wen, mem_ren, mem_cen} = pins_q;
    assign mem_addr = addr_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign sel      = sel_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_buffer_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buffer_port_arbiter
//
// Directed testbench for buffer_port_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_buffer_port_arbiter;

    localparam int AW = 13;
    localparam int LW = 7;

    localparam logic [2:0] P_WR  = 3'b011;
    localparam logic [2:0] P_RD  = 3'b110;
    localparam logic [2:0] P_NOP = 3'b101;

    logic          CLK;
    logic          RESET;
    logic          EN;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] base0, base1, base2;
    logic [LW-1:0] len0, len1, len2;
    logic [2:0]    gnt;
    logic [2:0]    done;
    logic [1:0]    sel;
    logic          busy;
    logic          mem_wen, mem_ren, mem_cen;
    logic [AW-1:0] mem_addr;
    logic [2:0]    pins;

    int n_tests;
    int n_fail;
    int beats;

    assign pins = {mem_wen, mem_ren, mem_cen};

    buffer_port_arbiter #(.AW(AW), .LW(LW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .req      (req),
        .we       (we),
        .base0    (base0),
        .base1    (base1),
        .base2    (base2),
        .len0     (len0),
        .len1     (len1),
        .len2     (len2),
        .gnt      (gnt),
        .done     (done),
        .sel      (sel),
        .busy     (busy),
        .mem_wen  (mem_wen),
        .mem_ren  (mem_ren),
        .mem_cen  (mem_cen),
        .mem_addr (mem_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: count it and report any mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RESET = 1'b0;
        EN    = 1'b0;
        req   = 3'b000;
        we    = 3'b000;
        base0 = '0; base1 = '0; base2 = '0;
        len0  = '0; len1  = '0; len2  = '0;

        // ---- reset state ----
        tick();
        check("rst_pins", 32'(pins), 32'(P_NOP));
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_gnt",  32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel",  32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        RESET = 1'b1;

        // ---- EN low in IDLE: no arbitration ----
        req = 3'b010;
        tick();
        tick();
        check("en0_pins", 32'(pins), 32'(P_NOP));
        check("en0_busy", 32'(busy), 32'd0);

        // ---- single read: requester 1, base 100, len 3 ----
        we = 3'b000; base1 = 13'd100; len1 = 7'd3; EN = 1'b1;
        tick();
        check("rd_gnt0",  32'(gnt), 32'd2);
        check("rd_addr0", 32'(mem_addr), 32'd100);
        check("rd_pins0", 32'(pins), 32'(P_RD));
        check("rd_sel0",  32'(sel), 32'd1);
        check("rd_busy0", 32'(busy), 32'd1);
        check("rd_done0", 32'(done), 32'd0);
        req = 3'b000;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check("rd_addr", 32'(mem_addr), 32'(100 + n));
            check("rd_pins", 32'(pins), 32'(P_RD));
            check("rd_gnt",  32'(gnt), 32'd0);
            check("rd_done", 32'(done), (n == 3) ? 32'd2 : 32'd0);
        end
        tick();
        check("rd_nop",  32'(pins), 32'(P_NOP));
        check("rd_idle", 32'(busy), 32'd0);
        check("rd_sel",  32'(sel), 32'd1);

        // ---- round robin after reset, all len 0 ----
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        len0 = 7'd0; len1 = 7'd0; len2 = 7'd0;
        base0 = 13'd10; base1 = 13'd20; base2 = 13'd30;
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_gnt",  32'(gnt), 32'(3'b001 << (i % 3)));
            check("rr_done", 32'(done), 32'(3'b001 << (i % 3)));
            check("rr_pins", 32'(pins), 32'(P_RD));
            check("rr_addr", 32'(mem_addr), 32'(10 + 10 * (i % 3)));
            tick();
            check("rr_gap", 32'(pins), 32'(P_NOP));
            if (i == 5) begin
                req = 3'b000;
            end else begin
                req = 3'b111;
            end
        end

        // ---- wrap and write: requester 0, base 8190, len 3 ----
        req = 3'b001; we = 3'b001; base0 = 13'd8190; len0 = 7'd3;
        tick();
        check("wr_gnt", 32'(gnt), 32'd1);
        req = 3'b000;
        for (int n = 0; n < 4; n++) begin
            if (n != 0) tick();
            check("wr_addr", 32'(mem_addr), 32'((8190 + n) % 8192));
            check("wr_pins", 32'(pins), 32'(P_WR));
            check("wr_done", 32'(done), (n == 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("wr_nop", 32'(pins), 32'(P_NOP));

        // ---- pause: requester 1, base 200, len 4, EN low 3 cycles after beat 1 ----
        we = 3'b000; base1 = 13'd200; len1 = 7'd4; req = 3'b010;
        beats = 0;
        tick();
        check("ps_gnt", 32'(gnt), 32'd2);
        if (pins == P_RD) beats++;
        req = 3'b000;
        tick();
        check("ps_addr1", 32'(mem_addr), 32'd201);
        if (pins == P_RD) beats++;
        EN = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            check("ps_nop",  32'(pins), 32'(P_NOP));
            check("ps_hold", 32'(mem_addr), 32'd202);
            check("ps_busy", 32'(busy), 32'd1);
            check("ps_gd",   32'({gnt, done}), 32'd0);
        end
        EN = 1'b1;
        for (int n = 2; n <= 4; n++) begin
            tick();
            check("ps_addr", 32'(mem_addr), 32'(200 + n));
            check("ps_done", 32'(done), (n == 4) ? 32'd2 : 32'd0);
            if (pins == P_RD) beats++;
        end
        tick();
        check("ps_end",   32'(pins), 32'(P_NOP));
        check("ps_beats", 32'(beats), 32'd5);

        // ---- reset mid-burst: requester 0, base 50, len 7 ----
        req = 3'b001; we = 3'b000; base0 = 13'd50; len0 = 7'd7;
        tick();
        tick();
        tick();
        check("mr_addr2", 32'(mem_addr), 32'd52);
        RESET = 1'b0;
        #1;
        check("mr_pins", 32'(pins), 32'(P_NOP));
        check("mr_addr", 32'(mem_addr), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        req = 3'b101; base0 = 13'd60; len0 = 7'd0; base2 = 13'd300; len2 = 7'd0;
        tick();
        check("mr_done2", 32'(done), 32'd0);
        RESET = 1'b1;
        tick();
        check("mr_win0", 32'(gnt), 32'd1);
        check("mr_addr60", 32'(mem_addr), 32'd60);
        req = 3'b000;
        tick();

        // ---- req drop: requester 2, base 400, len 5 ----
        req = 3'b100; base2 = 13'd400; len2 = 7'd5;
        beats = 0;
        tick();
        check("rq_gnt", 32'(gnt), 32'd4);
        if (pins == P_RD) beats++;
        req = 3'b000;
        for (int n = 1; n <= 5; n++) begin
            tick();
            check("rq_addr", 32'(mem_addr), 32'(400 + n));
            check("rq_done", 32'(done), (n == 5) ? 32'd4 : 32'd0);
            if (pins == P_RD) beats++;
        end
        check("rq_beats", 32'(beats), 32'd6);
        tick();
        check("rq_idle", 32'(busy), 32'd0);
        check("rq_nop",  32'(pins), 32'(P_NOP));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_port_arbiter.md
Name: buffer_port_arbiter

Overview:
- Shares one single-port on-chip buffer (input vector, binary map or sort result buffer) between three requesters: host loader (0), systolic array fetch (1), sort/crucial-token logic (2).
- Each requester asks for a burst of consecutive addresses. The arbiter grants round-robin and then drives the buffer's wen/ren/cen/addr for the whole burst.
- Steers the data mux by requester id, so the top-level controller no longer hand-sequences buffer pins per state.

Parameters:
- AW, 13, buffer address width.
- LW, 7, burst-length field width; a burst is len+1 beats, 1..2^LW.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- EN  input  1  global enable; low pauses arbitration and bursts.
- req  input  3  per-requester request level, bit k = requester k.
- we  input  3  per-requester direction: 1 write, 0 read.
- base0/base1/base2  input  AW each  burst start address per requester.
- len0/len1/len2  input  LW each  burst length minus one per requester.
- gnt  output  3  one-hot, one-cycle pulse on the first beat of a granted burst.
- done  output  3  one-hot, one-cycle pulse on the last beat.
- sel  output  2  id of the requester owning the current beat; holds its last value when idle.
- busy  output  1  high while a burst is in progress, including paused cycles.
- mem_wen  output  1  buffer write-enable (see encoding).
- mem_ren  output  1  buffer ren (see encoding).
- mem_cen  output  1  buffer cen (see encoding).
- mem_addr  output  AW  buffer address.

Behaviour:
- Buffer pin encoding {wen,ren,cen}, all outputs registered:
  - WRITE = 0,1,1
  - READ = 1,1,0
  - NOP = 1,0,1
- Reset values: state IDLE, mem pins NOP, mem_addr 0, gnt 0, done 0, sel 0, busy 0, round-robin pointer last = 2 (requester 0 has first priority).
- The reset is asynchronous. Asserting it mid-burst forces all outputs to reset values on the spot; no done is issued.
- FSM states: IDLE, BURST.
- IDLE:
  - Pins are NOP.
  - With EN=1 and req!=0, select winner k, the first set bit scanning last+1, last+2, last+3 (mod 3).
  - Latch we[k], base_k, len_k into local registers; beat counter = 0.
  - Go to BURST. The arbitration cycle itself produces no beat.
- BURST, beat n (n = 0..len):
  - mem_addr = base + n, modulo 2^AW; wraps past 2^AW-1 to 0.
  - Pins WRITE or READ per the latched we.
  - sel = k, busy = 1.
  - gnt[k] = 1 on beat 0 only; done[k] = 1 on beat len only.
  - len = 0 gives gnt and done in the same cycle.
- After the last beat: last <- k, return to IDLE.
  - At least one NOP cycle always separates bursts, which is the buffer turnaround.
  - Max throughput per burst: len+1 beats in len+2 cycles.
- req, we, base, len are sampled only in IDLE. Changing or dropping req mid-burst has no effect; the burst always completes.
- Requester protocol: a requester holding req after its done re-enters arbitration behind the other active requesters.
- EN=0 while in BURST:
  - Pins go NOP; mem_addr, counter, sel and busy hold; gnt and done are suppressed.
  - When EN returns to 1, the pending beat is issued, so no beat is skipped or repeated.
  - A gnt due on a paused beat 0 is emitted when that beat actually issues.
- EN=0 while in IDLE: no arbitration; the pointer holds.
- Read data returns from the buffer one cycle after the READ beat. The consumer qualifies it with a one-cycle-delayed copy of its own gnt/done window; the arbiter does not register data.
- Starvation bound: any requester holding req is granted within two other bursts.

Test Plan:
- Single read: req=3'b010, we1=0, base1=100, len1=3 → gnt[1] on the first READ beat; addr 100,101,102,103 with {1,1,0}; done[1] on addr 103; NOP next cycle; sel=1.
- Round-robin: req=3'b111 held continuously after reset, all len=0 → grant order 0,1,2,0,1,2; exactly one NOP cycle between beats.
- Wrap and write: req0, we0=1, base0=8190, len0=3 → addr 8190,8191,0,1 with {0,1,1}; done[0] on addr 1.
- Pause: burst len=4 with EN low for 3 cycles after beat 1 → NOP for 3 cycles, addr holds at beat-2 value, busy=1; resume issues beats 2,3,4; exactly 5 active beats total.
- Reset mid-burst: RESET low on beat 2 of a len=7 burst → pins NOP, addr 0, busy 0 without waiting for a clock; no done; after release requester 0 wins first if requesting.
- req drop: req2 deasserted after gnt, len2=5 → all 6 beats still issued; done[2] asserted.
